// File: rtl/req_queue_pkg.sv
// Shared definitions for the two-client request queue.
package req_queue_pkg;

    localparam int NUM_CLIENTS = 2;

    // Source tag carried with each output word.
    typedef logic [0:0] client_id_t;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/two_client_request_queue_if.sv
// Client streams, arbiter request/grant pair and the shared output bus.
interface two_client_request_queue_if #(
    parameter int WIDTH = 8
);
    import req_queue_pkg::*;

    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             stall;
    logic [1:0]       requests;
    logic [1:0]       grants;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    client_id_t       out_id;
    logic             protocol_error;

    // Clients, arbiter and downstream together, as seen from outside the queue.
    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, stall, grants,
        input  in0_ready, in1_ready, requests, out_valid, out_data, out_id,
        input  protocol_error
    );

    // The queue itself.
    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, stall, grants,
        output in0_ready, in1_ready, requests, out_valid, out_data, out_id,
        output protocol_error
    );

endinterface

// File: rtl/req_fifo.sv
// Single-client circular FIFO; head is the oldest word, visible combinationally.
module req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // Ready is judged on the registered count, so a full queue never
    // takes a word even when it is being popped in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= data;
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/two_client_request_queue.sv
// Two per-client FIFOs feeding a round-robin arbiter; pops the granted queue
// onto a single tagged output and flags grant-protocol violations.
module two_client_request_queue
    import req_queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic                        clk,
    input logic                        rst,
    two_client_request_queue_if.slave  bus
);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [NUM_CLIENTS-1:0]            in_valid;
    logic [NUM_CLIENTS-1:0][WIDTH-1:0] in_data;
    logic [NUM_CLIENTS-1:0]            ready;
    logic [NUM_CLIENTS-1:0]            push;
    logic [NUM_CLIENTS-1:0]            pop;
    logic [NUM_CLIENTS-1:0]            req;
    logic [NUM_CLIENTS-1:0][WIDTH-1:0] head;
    logic [NUM_CLIENTS-1:0][CW-1:0]    count;
    logic [NUM_CLIENTS-1:0]            full;
    logic [NUM_CLIENTS-1:0]            empty;
    logic                              grant_both;
    logic                              err_now;
    logic                              err_q;

    assign in_valid = {bus.in1_valid, bus.in0_valid};
    assign in_data  = {bus.in1_data,  bus.in0_data};

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
        assign ready[i] = (count[i] != FULL_CNT);
        assign push[i]  = in_valid[i] & ~full[i];

        req_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .data  (in_data[i]),
            .pop   (pop[i]),
            .head  (head[i]),
            .count (count[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    assign bus.in0_ready = ready[0];
    assign bus.in1_ready = ready[1];

    // Requests come only from registered occupancy and stall, so the arbiter
    // can answer in the same cycle without a combinational loop. Reset masks
    // them so nothing is granted or output while the queues are being cleared.
    assign req          = ~empty & {NUM_CLIENTS{~stall_or_rst()}};
    assign bus.requests = req;

    function automatic logic stall_or_rst();
        return bus.stall | rst;
    endfunction

    // A double grant pops nothing; a grant on an idle request is ignored.
    assign grant_both = (bus.grants == 2'b11);
    assign pop        = grant_both ? '0 : (bus.grants & req);
    assign err_now    = grant_both | (|(bus.grants & ~req));

    // Output mux: head of the popped queue, tagged with its source, else zeros.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_id    = '0;
        bus.out_data  = '0;
        if (pop[1]) begin
            bus.out_valid = 1'b1;
            bus.out_id    = client_id_t'(1);
            bus.out_data  = head[1];
        end else if (pop[0]) begin
            bus.out_valid = 1'b1;
            bus.out_id    = client_id_t'(0);
            bus.out_data  = head[0];
        end
    end

    // Sticky violation flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (err_now)
            err_q <= 1'b1;
    end

    assign bus.protocol_error = err_q;

endmodule
